// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held per bus cycle
// and a per-transaction ack watchdog that aborts a hung slave access.
module wb_master_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CW       = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic          last_grant;   // 0: M0 was granted last, 1: M1
    logic [CW-1:0] wd_cnt;
    logic [1:0]    grant_q;
    logic          timeout_q;

    logic          req0;
    logic          req1;
    logic          granted;
    logic          sel_m1;
    logic          m_cyc;
    logic          m_stb;
    logic          m_we;
    logic [3:0]    m_sel;
    logic [31:0]   m_adr;
    logic [31:0]   m_dat;
    logic          ack_fwd;
    logic          wd_hit;
    logic          abort0;
    logic          abort1;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign granted = (state == GRANT0) || (state == GRANT1);
    assign sel_m1  = (state == GRANT1);

    // Granted-master view of the bus request.
    assign m_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign m_stb = sel_m1 ? m1_stb_i : m0_stb_i;
    assign m_we  = sel_m1 ? m1_we_i  : m0_we_i;
    assign m_sel = sel_m1 ? m1_sel_i : m0_sel_i;
    assign m_adr = sel_m1 ? m1_adr_i : m0_adr_i;
    assign m_dat = sel_m1 ? m1_dat_i : m0_dat_i;

    // An ack in the same cycle the watchdog would expire wins over the abort.
    assign ack_fwd = granted & m_cyc & s_ack_i;
    assign wd_hit  = granted & m_cyc & m_stb & ~s_ack_i & (wd_cnt == WD_LAST);

    // The aborted master is the one granted last, since entry to a grant records it.
    assign abort0 = (state == ABORT) & ~last_grant;
    assign abort1 = (state == ABORT) &  last_grant;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_grant ? GRANT0 : GRANT1;
                end else if (req0) begin
                    next_state = GRANT0;
                end else if (req1) begin
                    next_state = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!m_cyc) begin
                    next_state = IDLE;
                end else if (wd_hit) begin
                    next_state = ABORT;
                end
            end
            ABORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'd0;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        if (granted) begin
            s_cyc_o = m_cyc;
            s_stb_o = m_cyc & m_stb;
            s_we_o  = m_we;
            s_sel_o = m_sel;
            s_adr_o = m_adr;
            s_dat_o = m_dat;
        end
    end

    always_comb begin
        m0_ack_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'd0;
        if (state == GRANT0) begin
            m0_ack_o = ack_fwd;
            m0_dat_o = s_dat_i;
        end else if (state == GRANT1) begin
            m1_ack_o = ack_fwd;
            m1_dat_o = s_dat_i;
        end else if (abort0) begin
            m0_ack_o = 1'b1;
            m0_dat_o = ERR_DATA;
        end else if (abort1) begin
            m1_ack_o = 1'b1;
            m1_dat_o = ERR_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT0) begin
                last_grant <= 1'b0;
            end else if (state == IDLE && next_state == GRANT1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // Watchdog only runs while a grant is active; anywhere else it rests at zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt <= '0;
        end else if (!granted || s_ack_i) begin
            wd_cnt <= '0;
        end else if (m_cyc && m_stb && next_state != ABORT) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            grant_q   <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (next_state == ABORT);
            unique case (next_state)
                GRANT0:  grant_q <= 2'b01;
                GRANT1:  grant_q <= 2'b10;
                default: grant_q <= 2'b00;
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule
